req_encoder: RTL and testbench

- Sequential N-to-log2(N) request encoder. It is the encode-side counterpart of the team's 2x4 decoder.
- It collects request pulses on N one-hot lines into a pending register and grants them one at a time with round-robin priority.
- Each grant is presented as a binary index plus a one-hot copy, under a valid/ready handshake.
- It sits between event sources (interrupt-style pulses) and a consumer that takes one encoded event per transfer.

---
 rtl/req_encoder_pkg.sv | 15 +
 rtl/req_encoder_rr_select.sv | 34 +++
 rtl/req_encoder.sv | 91 +++++++++
 tb/tb_req_encoder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/req_encoder_pkg.sv
// Shared types for the round-robin request encoder.
// Holds the FSM state encoding and the index-width helper.
package req_encoder_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Width of a binary index for n lines; never below one bit.
   function automatic int idx_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/req_encoder_rr_select.sv
// Rotating priority selector: first set bit of cand at or after ptr.
// Ports: cand/ptr in; found, idx and onehot (decode of idx) out.
module rr_select
   import req_encoder_pkg::*;
#(
   parameter int N = 4,
   parameter int W = idx_width(N)
) (
   input  logic [N-1:0] cand,
   input  logic [W-1:0] ptr,
   output logic         found,
   output logic [W-1:0] idx,
   output logic [N-1:0] onehot
);

   logic [W-1:0] pos;

   // N is a power of two, so W-bit addition wraps modulo N.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int i = 0; i < N; i++) begin
         pos = ptr + W'(i);
         if (!found && cand[pos]) begin
            found = 1'b1;
            idx   = pos;
         end
      end
      onehot      = '0;
      onehot[idx] = found;
   end

endmodule

// File: rtl/req_encoder.sv
// Sequential N-to-log2(N) request encoder with round-robin grants.
// Ports: clk, rst (async high), req_in, out_ready in; out_valid,
// out_idx, out_onehot, pending_o, overflow out.
module req_encoder
   import req_encoder_pkg::*;
#(
   parameter  int N = 4,
   localparam int W = idx_width(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_in,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] out_onehot,
   output logic [N-1:0] pending_o,
   output logic         overflow
);

   state_t       state;
   logic [W-1:0] ptr;
   logic [N-1:0] pending;
   logic         hs;
   logic [N-1:0] served;
   logic [N-1:0] cand;
   logic [W-1:0] nxt_ptr;
   logic [W-1:0] sel_ptr;
   logic         found;
   logic [W-1:0] sel_idx;
   logic [N-1:0] sel_onehot;

   assign out_valid = (state == GRANT);
   assign pending_o = pending;

   assign hs      = out_valid & out_ready;
   assign served  = hs ? out_onehot : '0;
   assign cand    = (pending & ~served) | req_in;
   assign nxt_ptr = out_idx + W'(1);
   // Back-to-back grants search from the slot after the one served.
   assign sel_ptr = hs ? nxt_ptr : ptr;

   rr_select #(
      .N (N),
      .W (W)
   ) u_sel (
      .cand   (cand),
      .ptr    (sel_ptr),
      .found  (found),
      .idx    (sel_idx),
      .onehot (sel_onehot)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= '0;
         pending    <= '0;
         out_idx    <= '0;
         out_onehot <= '0;
         overflow   <= 1'b0;
      end else begin
         pending  <= cand;
         // A bit being served and re-requested is a fresh request.
         overflow <= |(req_in & pending & ~served);
         unique case (state)
            IDLE: begin
               if (found) begin
                  out_idx    <= sel_idx;
                  out_onehot <= sel_onehot;
                  state      <= GRANT;
               end
            end
            GRANT: begin
               if (hs) begin
                  ptr <= nxt_ptr;
                  if (found) begin
                     out_idx    <= sel_idx;
                     out_onehot <= sel_onehot;
                  end else begin
                     out_onehot <= '0;
                     state      <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_req_encoder.sv
// Bench for req_encoder: list-based reference model checked every cycle
// plus directed literal checks on the listed scenarios.
module tb_req_encoder;

   localparam int N = 4;
   localparam int W = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req_in = '0;
   logic         out_ready = 1'b0;
   logic         out_valid;
   logic [W-1:0] out_idx;
   logic [N-1:0] out_onehot;
   logic [N-1:0] pending_o;
   logic         overflow;

   int total = 0;
   int bad   = 0;
   bit run   = 0;

   req_encoder #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_in     (req_in),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_idx    (out_idx),
      .out_onehot (out_onehot),
      .pending_o  (pending_o),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Reference model: a set of waiting lines, a start slot, a current grant.
   bit m_wait [N];
   int m_ptr;
   bit m_valid;
   int m_idx;
   bit m_ovf;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) m_wait[i] = 0;
         m_ptr = 0; m_valid = 0; m_idx = 0; m_ovf = 0;
      end else begin
         int  srv;
         bit  nw [N];
         bit  ov;
         srv = (m_valid && out_ready) ? m_idx : -1;
         ov  = 0;
         for (int i = 0; i < N; i++) begin
            if (req_in[i] && m_wait[i] && i != srv) ov = 1;
            nw[i] = (m_wait[i] && i != srv) || req_in[i];
         end
         if (srv >= 0) m_ptr = (srv + 1) % N;
         if (!m_valid || srv >= 0) begin
            m_valid = 0;
            for (int k = 0; k < N; k++) begin
               if (!m_valid && nw[(m_ptr + k) % N]) begin
                  m_valid = 1;
                  m_idx   = (m_ptr + k) % N;
               end
            end
         end
         for (int i = 0; i < N; i++) m_wait[i] = nw[i];
         m_ovf = ov;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (run && !rst) begin
         int ep;
         int eo;
         ep = 0;
         for (int i = 0; i < N; i++) if (m_wait[i]) ep |= (1 << i);
         eo = m_valid ? (1 << m_idx) : 0;
         chk("m_valid", int'(out_valid), int'(m_valid));
         if (m_valid) chk("m_idx", int'(out_idx), m_idx);
         chk("m_onehot", int'(out_onehot), eo);
         chk("m_pending", int'(pending_o), ep);
         chk("m_overflow", int'(overflow), int'(m_ovf));
      end
   end

   task automatic drive(input logic [N-1:0] r, input logic y);
      @(posedge clk);
      #2;
      req_in    = r;
      out_ready = y;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      req_in = '0;
      out_ready = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b0;
   endtask

   initial begin
      #12;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_idx", int'(out_idx), 0);
      chk("rst_onehot", int'(out_onehot), 0);
      chk("rst_pending", int'(pending_o), 0);
      chk("rst_overflow", int'(overflow), 0);
      rst = 1'b0;
      run = 1;

      // Idle with ready high.
      for (int k = 0; k < 5; k++) drive(4'b0000, 1'b1);
      chk("idle_valid", int'(out_valid), 0);
      chk("idle_pending", int'(pending_o), 0);

      // Single request on line 2.
      drive(4'b0100, 1'b1);
      drive(4'b0000, 1'b1);
      chk("t2_valid", int'(out_valid), 1);
      chk("t2_idx", int'(out_idx), 2);
      chk("t2_onehot", int'(out_onehot), 4'b0100);
      drive(4'b0000, 1'b1);
      chk("t2_done_valid", int'(out_valid), 0);
      chk("t2_done_pending", int'(pending_o), 0);
      // ptr is now 3, so line 3 wins over line 0.
      drive(4'b1001, 1'b1);
      drive(4'b0000, 1'b1);
      chk("t2_ptr3_idx", int'(out_idx), 3);
      drive(4'b0000, 1'b1);
      chk("t2_wrap_idx", int'(out_idx), 0);
      for (int k = 0; k < 3; k++) drive(4'b0000, 1'b1);

      // All lines held: 0,1,2,3,0 with no bubble.
      do_reset();
      drive(4'b1111, 1'b1);
      for (int k = 0; k < 5; k++) begin
         drive(4'b1111, 1'b1);
         chk("t3_valid", int'(out_valid), 1);
         chk("t3_idx", int'(out_idx), k % N);
      end
      for (int k = 0; k < 6; k++) drive(4'b0000, 1'b1);

      // Stall with grant on line 1, then overflow and wrap.
      do_reset();
      drive(4'b0010, 1'b0);
      drive(4'b0000, 1'b0);
      chk("t4_idx_a", int'(out_idx), 1);
      drive(4'b0001, 1'b0);
      drive(4'b0010, 1'b0);
      chk("t4_ovf_a", int'(overflow), 0);
      chk("t4_pend", int'(pending_o), 4'b0011);
      drive(4'b0000, 1'b0);
      chk("t4_ovf_b", int'(overflow), 1);
      chk("t4_idx_b", int'(out_idx), 1);
      drive(4'b0000, 1'b1);
      chk("t4_ovf_c", int'(overflow), 0);
      drive(4'b0000, 1'b1);
      chk("t4_next_idx", int'(out_idx), 0);
      chk("t4_next_pend", int'(pending_o), 4'b0001);
      drive(4'b0000, 1'b1);
      chk("t4_end_valid", int'(out_valid), 0);

      // Re-request of the line being served.
      do_reset();
      drive(4'b1000, 1'b0);
      drive(4'b1000, 1'b1);
      chk("t5_idx_a", int'(out_idx), 3);
      drive(4'b0000, 1'b1);
      chk("t5_ovf", int'(overflow), 0);
      chk("t5_idx_b", int'(out_idx), 3);
      chk("t5_pend", int'(pending_o), 4'b1000);
      drive(4'b0000, 1'b1);
      chk("t5_end_valid", int'(out_valid), 0);

      // Asynchronous reset in the middle of a grant.
      do_reset();
      drive(4'b0110, 1'b0);
      drive(4'b0000, 1'b0);
      chk("t6_pend", int'(pending_o), 4'b0110);
      chk("t6_idx", int'(out_idx), 1);
      #1;
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", int'(out_valid), 0);
      chk("t6_rst_onehot", int'(out_onehot), 0);
      chk("t6_rst_pend", int'(pending_o), 0);
      @(posedge clk);
      #3;
      rst = 1'b0;
      drive(4'b1010, 1'b1);
      drive(4'b0000, 1'b1);
      chk("t6_first_idx", int'(out_idx), 1);
      drive(4'b0000, 1'b1);
      chk("t6_second_idx", int'(out_idx), 3);
      for (int k = 0; k < 3; k++) drive(4'b0000, 1'b1);

      run = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
